// File: rtl/sram_stream_reader.sv
// DMA read channel: walks a descriptor through the SRAM and streams the words out
// over valid/ready, hiding the one-cycle read latency behind a 3-entry buffer.
module sram_stream_reader #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              inst_clk,
  input  logic              inst_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              sram_cs_n,
  output logic              sram_wr_n,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned OCC_W = 3;
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  last_addr_q;
  logic [LEN_W-1:0]   remaining_q;
  logic [LEN_W-1:0]   outstanding_q;
  logic               in_flight_q;

  logic [DATA_W-1:0]  buf_q [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [PTR_W-1:0]   count_q;

  logic [OCC_W-1:0]   credit_c;
  logic               issue_c;
  logic               pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A read may only go out if its word is guaranteed a buffer slot on return.
  always_comb begin
    credit_c = OCC_W'(count_q) + OCC_W'(in_flight_q);
    issue_c  = (state == RUN) && (remaining_q != '0) && (credit_c < OCC_W'(DEPTH));
    pop_c    = (count_q != '0) && m_ready;
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign sram_wr_n = 1'b1;
  assign sram_cs_n = ~issue_c;
  assign sram_addr = issue_c ? addr_q : last_addr_q;
  assign m_valid   = (count_q != '0);
  assign m_data    = buf_q[head_q];
  assign m_last    = m_valid && (outstanding_q == LEN_W'(1));

  // Transfer sequencing and address/length bookkeeping.
  always_ff @(posedge inst_clk or posedge inst_rst) begin
    if (inst_rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      last_addr_q   <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      in_flight_q   <= 1'b0;
    end else begin
      in_flight_q <= issue_c;
      if (issue_c) begin
        addr_q      <= addr_q + ADDR_W'(1);
        last_addr_q <= addr_q;
        remaining_q <= remaining_q - LEN_W'(1);
      end
      if (pop_c) begin
        outstanding_q <= outstanding_q - LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q        <= cmd_addr;
            remaining_q   <= cmd_len;
            outstanding_q <= cmd_len;
            state         <= (cmd_len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if ((remaining_q == '0) || (issue_c && (remaining_q == LEN_W'(1)))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((outstanding_q == '0) || (pop_c && (outstanding_q == LEN_W'(1)))) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read-return buffer; capture is unconditional because issue reserved the slot.
  always_ff @(posedge inst_clk or posedge inst_rst) begin
    if (inst_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      if (in_flight_q) begin
        buf_q[tail_q] <= sram_rdata;
        tail_q        <= ptr_inc(tail_q);
      end
      if (pop_c) begin
        head_q <= ptr_inc(head_q);
      end
      case ({in_flight_q, pop_c})
        2'b10:   count_q <= count_q + PTR_W'(1);
        2'b01:   count_q <= count_q - PTR_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: descriptor table plus corner sequences, with a
// scoreboard of expected SRAM addresses and output words.
module tb_sram_stream_reader;

  logic        clk = 1'b0;
  logic        inst_rst = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_addr;
  logic [9:0]  cmd_len;
  logic        sram_cs_n;
  logic        sram_wr_n;
  logic [8:0]  sram_addr;
  logic [63:0] sram_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  sram_stream_reader #(.DATA_W(64), .ADDR_W(9)) dut (
    .inst_clk(clk), .inst_rst(inst_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .sram_cs_n(sram_cs_n), .sram_wr_n(sram_wr_n), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [63:0] ram [512];
  initial sram_rdata = '0;
  always @(posedge clk) begin
    if (!sram_cs_n && sram_wr_n) sram_rdata <= ram[sram_addr];
  end

  typedef struct packed { logic [63:0] data; logic last; } exp_t;
  typedef struct { logic [8:0] addr; logic [9:0] len; int mode; int lat; } vec_t;

  exp_t       data_q[$];
  logic [8:0] addr_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0, done_cyc = 0, ev_cyc = 0;
  int acc_count = 0, done_count = 0, words_seen = 0;
  int issued = 0, popped = 0;
  int m_mode = 0;
  logic pending_done = 1'b0, first_issue = 1'b0, first_valid = 1'b0;
  logic held = 1'b0;
  logic [63:0] held_data;
  logic held_last;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Downstream ready generator: 0 = always ready, 1 = 1-0-0-1 then 5 low, 2 = random.
  initial begin
    logic [8:0] pat;
    int phase;
    pat = 9'b000001001;
    phase = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (m_mode)
        1: begin m_ready = pat[phase]; phase = (phase + 1) % 9; end
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (inst_rst) begin
      data_q.delete();
      addr_q.delete();
      pending_done = 1'b0;
      first_issue = 1'b0;
      first_valid = 1'b0;
      held = 1'b0;
      issued = 0;
      popped = 0;
    end else begin
      if (!sram_wr_n) fail_now("sram_wr_n_low");
      check("cmd_ready_vs_busy", cmd_ready, !busy);
      if (!sram_cs_n) begin
        if (addr_q.size() == 0) fail_now("unexpected_sram_read");
        else check("sram_addr", sram_addr, addr_q.pop_front());
        if (first_issue) begin
          check("first_issue_cycle", 64'(cyc), 64'(acc_cyc + 1));
          first_issue = 1'b0;
        end
        issued++;
        if (issued - popped > 3) fail_now("reads_ahead_over_3");
      end
      if (m_valid) begin
        if (first_valid) begin
          check("first_valid_cycle", 64'(cyc), 64'(acc_cyc + 3));
          first_valid = 1'b0;
        end
        if (held) begin
          check("stall_data_stable", m_data, held_data);
          check("stall_last_stable", m_last, held_last);
        end
        if (data_q.size() == 0) begin
          fail_now("spurious_m_valid");
        end else if (m_ready) begin
          exp_t e;
          e = data_q.pop_front();
          check("m_data", m_data, e.data);
          check("m_last", m_last, e.last);
          popped++;
          words_seen++;
          held = 1'b0;
          if (data_q.size() == 0) ev_cyc = cyc;
        end else begin
          held = 1'b1;
          held_data = m_data;
          held_last = m_last;
        end
      end else begin
        held = 1'b0;
      end
      if (done) begin
        check("done_expected", pending_done, 1'b1);
        check("done_cycle", 64'(cyc), 64'(ev_cyc + 1));
        pending_done = 1'b0;
        done_cyc = cyc;
        done_count++;
      end
      if (cmd_valid && cmd_ready) begin
        for (int i = 0; i < int'(cmd_len); i++) begin
          logic [8:0] a;
          exp_t e;
          a = cmd_addr + 9'(i);
          e.data = 64'(a) + 64'h100;
          e.last = (i == int'(cmd_len) - 1);
          addr_q.push_back(a);
          data_q.push_back(e);
        end
        pending_done = 1'b1;
        ev_cyc = cyc;
        acc_cyc = cyc;
        first_issue = (cmd_len != '0);
        first_valid = (cmd_len != '0);
        words_seen = 0;
        acc_count++;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    check({tag, "_sram_cs_n"}, sram_cs_n, 1'b1);
    check({tag, "_sram_wr_n"}, sram_wr_n, 1'b1);
    check({tag, "_sram_addr"}, sram_addr, 9'h000);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_data"}, m_data, 64'h0);
    check({tag, "_m_last"}, m_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  task automatic wait_accept(input int a0, input string name);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      if (acc_count != a0) got = 1'b1;
    end
    if (!got) fail_now({name, "_accept_timeout"});
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    logic got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(posedge clk);
      if (done_count != d0) got = 1'b1;
    end
    if (!got) fail_now({name, "_done_timeout"});
  endtask

  task automatic run_desc(input logic [8:0] a, input logic [9:0] l, input int lat, input string name);
    int a0, d0;
    @(posedge clk);
    #1;
    a0 = acc_count;
    d0 = done_count;
    cmd_addr = a;
    cmd_len = l;
    cmd_valid = 1'b1;
    wait_accept(a0, name);
    #1;
    cmd_valid = 1'b0;
    wait_done(d0, 6 * int'(l) + 60, name);
    if (lat != 0) check({name, "_accept_to_done"}, 64'(done_cyc - acc_cyc), 64'(lat));
    @(negedge clk);
    check({name, "_busy_after"}, busy, 1'b0);
    check({name, "_ready_after"}, cmd_ready, 1'b1);
    check({name, "_words_left"}, 64'(data_q.size()), 64'd0);
    check({name, "_reads_left"}, 64'(addr_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int a0, d0;
    logic got;

    tbl[0] = '{addr: 9'h010, len: 10'd4,   mode: 0, lat: 7};
    tbl[1] = '{addr: 9'h1FE, len: 10'd4,   mode: 0, lat: 7};
    tbl[2] = '{addr: 9'h020, len: 10'd8,   mode: 1, lat: 0};
    tbl[3] = '{addr: 9'h0AA, len: 10'd0,   mode: 0, lat: 1};
    tbl[4] = '{addr: 9'h100, len: 10'd16,  mode: 2, lat: 0};
    tbl[5] = '{addr: 9'h005, len: 10'd1,   mode: 0, lat: 4};
    tbl[6] = '{addr: 9'h1FF, len: 10'd3,   mode: 1, lat: 0};
    tbl[7] = '{addr: 9'h1F0, len: 10'd512, mode: 0, lat: 515};

    for (int k = 0; k < 512; k++) ram[k] = 64'(k) + 64'h100;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;

    #1 inst_rst = 1'b1;
    #1 check_reset_vals("por");
    repeat (3) @(posedge clk);
    #1 inst_rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      m_mode = tbl[i].mode;
      run_desc(tbl[i].addr, tbl[i].len, tbl[i].lat, $sformatf("vec%0d", i));
    end

    // Second descriptor held valid throughout the first transfer.
    m_mode = 0;
    @(posedge clk);
    #1;
    a0 = acc_count;
    d0 = done_count;
    cmd_addr = 9'h030;
    cmd_len = 10'd5;
    cmd_valid = 1'b1;
    wait_accept(a0, "held1");
    #1;
    cmd_addr = 9'h040;
    cmd_len = 10'd3;
    wait_accept(a0 + 1, "held2");
    check("held_accept_after_done", 64'(acc_cyc), 64'(done_cyc + 1));
    check("held_done_count", 64'(done_count - d0), 64'd1);
    #1;
    cmd_valid = 1'b0;
    wait_done(d0 + 1, 80, "held2");
    @(negedge clk);
    check("held_words_left", 64'(data_q.size()), 64'd0);

    // Reset in the middle of a 6-word transfer, then a clean 3-word transfer.
    @(posedge clk);
    #1;
    a0 = acc_count;
    d0 = done_count;
    cmd_addr = 9'h050;
    cmd_len = 10'd6;
    cmd_valid = 1'b1;
    wait_accept(a0, "mid");
    #1;
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      if (words_seen >= 2) got = 1'b1;
    end
    if (!got) fail_now("mid_two_words_timeout");
    #1;
    inst_rst = 1'b1;
    cmd_addr = 9'h080;
    cmd_len = 10'd3;
    cmd_valid = 1'b1;
    #1 check_reset_vals("midrst");
    a0 = acc_count;
    repeat (3) @(posedge clk);
    #1;
    check("no_accept_in_reset", 64'(acc_count), 64'(a0));
    check("no_done_in_reset", 64'(done_count), 64'(d0));
    inst_rst = 1'b0;
    wait_accept(a0, "post");
    #1;
    cmd_valid = 1'b0;
    wait_done(d0, 60, "post");
    check("post_accept_to_done", 64'(done_cyc - acc_cyc), 64'd6);
    @(negedge clk);
    check("post_words_left", 64'(data_q.size()), 64'd0);
    check("post_busy_after", busy, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- DMA read channel placed directly upstream of the behavioural SRAM model. It issues SRAM reads and consumes the SRAM's registered read data.
- Accepts a descriptor (start address, word count) and reads the words in sequence.
- Presents the words as a valid/ready stream to the downstream DMA datapath.
- Absorbs the SRAM's one-cycle read latency and downstream backpressure with an internal 3-entry buffer.

Parameters:
DATA_W, 64, SRAM word width; must equal SRAM_WIDTH
ADDR_W, 9, SRAM address width; depth is 2^ADDR_W = 512 words

Ports:
inst_clk  in  1  clock, rising edge
inst_rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  descriptor accepted when cmd_valid & cmd_ready at a clock edge
cmd_addr  in  ADDR_W  start word address
cmd_len  in  ADDR_W+1  word count, 0..512
sram_cs_n  out  1  SRAM chip select, active-low
sram_wr_n  out  1  SRAM write enable, active-low; tied to 1 (read only)
sram_addr  out  ADDR_W  SRAM read address
sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read is issued
m_valid  out  1  output word valid
m_ready  in  1  downstream ready
m_data  out  DATA_W  output word
m_last  out  1  marks the final word of the descriptor
busy  out  1  high from descriptor accept until done
done  out  1  one-cycle pulse when the transfer completes

Behaviour:
- Reset (async, active-high): state IDLE, buffer flushed, in-flight flag cleared, counters zero.
  - Output values under reset: cmd_ready=1, sram_cs_n=1, sram_wr_n=1, sram_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.
  - No descriptor is accepted while inst_rst is high.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: cmd_ready=1. On accept, latch addr, remaining=cmd_len and outstanding=cmd_len. Go to RUN if cmd_len != 0, else go to DONE.
  - RUN: issue reads, then go to DRAIN when remaining reaches 0.
  - DRAIN: wait until outstanding reaches 0, i.e. the last word is popped.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - cmd_ready=0 in all states except IDLE; cmd_valid is ignored while busy.
- busy=1 in RUN, DRAIN and DONE.
- Read issue (RUN only):
  - Combinational condition: remaining>0 and (buffer occupancy + in-flight) < 3.
  - When it holds: sram_cs_n=0, sram_addr=current addr. Otherwise sram_cs_n=1, and sram_addr holds its last value.
  - On each issue: addr <= addr+1 modulo 512 (wraps 511->0), remaining decrements, in-flight set for one cycle.
- Capture:
  - The cycle after an issue, sram_rdata is written into the buffer.
  - The write is unconditional. The credit rule guarantees space.
- Output:
  - m_valid = buffer not empty. m_data and m_last come from the buffer head.
  - A pop happens on m_valid & m_ready. Each pop decrements outstanding.
  - m_last=1 on the head word exactly when outstanding==1.
  - m_data and m_last are stable while m_valid=1 and m_ready=0.
- Simultaneous capture and pop in the same cycle: occupancy unchanged, order preserved.
- Latency and throughput:
  - Descriptor accepted at edge E0: the first sram_cs_n=0 is in the cycle after E0, the first m_valid is after E2.
  - With m_ready held at 1: one word per cycle, no bubbles.
- done:
  - Pulses the cycle after the pop of the last word.
  - cmd_ready returns to 1 the cycle after done.
  - For cmd_len=0, done pulses the cycle after accept, with no SRAM access.
- cmd_len > 512 is not representable. cmd_len = 512 reads the whole memory, wrapping from the start address.
- Reset mid-transfer: all in-flight and buffered data is discarded, and done is not asserted.

Test Plan:
- Preload ram[k]=k+0x100. Descriptor addr=0x010, len=4, m_ready=1 -> sram_addr 0x010..0x013 on 4 consecutive cycles; m_data 0x110..0x113 back-to-back; m_last on 0x113; done 1 cycle later; busy low after.
- Wrap: addr=0x1FE, len=4 -> sram_addr 0x1FE, 0x1FF, 0x000, 0x001; data order matches.
- Backpressure: len=8, m_ready toggled 1-0-0-1 pattern and held low 5 cycles -> at most 3 reads ahead of pops; no word lost or duplicated; m_data stable while stalled; 8 words delivered in order.
- len=0 -> no sram_cs_n=0 ever; m_valid stays 0; done pulses the cycle after accept.
- A second cmd_valid held high during a transfer -> not accepted until the cycle after done; then the new descriptor starts normally.
- Assert inst_rst mid-transfer (after 2 of 6 words) -> all outputs take reset values immediately; done never asserts; a following len=3 transfer completes correctly.
